// File: rtl/trace_step_assembler.sv
// Assembles 18 x 32-bit loader words into one 560-bit trace step with a
// holding register, length checking against in_last and error counting.
module trace_step_assembler #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [559:0]      step,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [31:0]       step_count
);

    typedef enum logic {
        FILL,
        RESYNC
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'd17;

    state_t            state, state_next;
    logic [4:0]        idx, idx_next;
    logic [16:0][31:0] fill_buf;
    logic              accept;
    logic              take;
    logic              load;
    logic              err_event;

    // Only the final word can stall: it needs the output register to be free.
    assign in_ready = (state == RESYNC) ||
                      !(idx == LAST_IDX && step_valid && !step_ready);
    assign accept   = in_valid && in_ready;
    assign take     = step_valid && step_ready;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        err_event  = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        idx_next = 5'd0;
                        if (in_last) begin
                            load = 1'b1;
                        end else begin
                            err_event  = 1'b1;
                            state_next = RESYNC;
                        end
                    end else if (in_last) begin
                        idx_next  = 5'd0;
                        err_event = 1'b1;
                    end else begin
                        idx_next = idx + 5'd1;
                    end
                end
            end
            RESYNC: begin
                idx_next = 5'd0;
                if (accept && in_last) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = 5'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            idx   <= 5'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: the fill buffer and step register are reset explicitly because
    // the cleared step is visible on the port straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_buf   <= '0;
            step       <= '0;
            step_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            step_count <= '0;
        end else begin
            if (accept && state == FILL && idx != LAST_IDX) begin
                fill_buf[idx] <= in_data;
            end

            if (load) begin
                step       <= {in_data[15:0], fill_buf};
                step_valid <= 1'b1;
            end else if (take) begin
                step_valid <= 1'b0;
            end

            if (take) begin
                step_count <= step_count + 32'd1;
            end

            frame_err <= err_event;
            if (err_event && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/trace_step_assembler.md
# trace_step_assembler

Builds the 560-bit trace step consumed by the tiny86 core from a 32-bit word stream delivered by the trace loader. It holds one completed step in an output register while the next step fills. It also checks frame length against the `in_last` marker, discarding malformed frames and counting them. It sits between the trace memory/DMA interface and the combinational `step` input of the core.

## Interface
- `CNT_W`, default 16: width of `err_count`, which saturates at its maximum.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  assembler accepts a word this cycle.
- `in_data`  in  32  input word.
- `in_last`  in  1  marks the final word of a frame.
- `step_valid`  out  1  `step` holds a complete frame.
- `step_ready`  in  1  consumer takes `step` this cycle.
- `step`  out  560  assembled trace step.
- `frame_err`  out  1  one-cycle pulse when a malformed frame is dropped.
- `err_count`  out  CNT_W  saturating count of dropped frames.
- `step_count`  out  32  count of steps handed off; wraps modulo 2^32.

## Operation
- Frame layout: 18 words.
  - Word k (k = 0..16) fills bits [32k+31:32k] of the step.
  - Word 17 fills bits [559:544] from `in_data[15:0]`; `in_data[31:16]` of word 17 is ignored.
- Word handshake: a word is accepted when `in_valid && in_ready`. Output handshake: a step is taken when `step_valid && step_ready`.
- Word index `idx` (0..17) selects the destination slice of the fill buffer.
- States:
  - FILL: accept words and write the slice at `idx`.
  - Good frame: word 17 is accepted with `in_last` = 1.
    - The fill buffer plus word 17 is copied to the output register and `step_valid` is set.
    - `idx` returns to 0 and the state stays FILL.
  - Short frame: `in_last` = 1 on a word with `idx` < 17.
    - The partial frame is discarded, `idx` returns to 0 and the state stays FILL.
    - `frame_err` pulses and `err_count` increments.
  - Long frame: word 17 is accepted with `in_last` = 0.
    - The frame is discarded; `frame_err` pulses and `err_count` increments.
    - The state moves to RESYNC.
  - RESYNC: `in_ready` = 1; all words are dropped. A word accepted with `in_last` = 1 returns the state to FILL with `idx` = 0. No further error is counted for the dropped words.
- Output register:
  - `step_valid` clears on handshake unless a new step loads in the same cycle.
  - `step_count` increments on each output handshake.
- Back-pressure: in FILL, `in_ready` = !(`idx` == 17 && `step_valid` && !`step_ready`).
  - Words 0..16 are never stalled by a full output register.
  - `in_ready` is 1 in RESYNC.
- Simultaneous events: on the same cycle as an output handshake, word 17 may be accepted and loaded. `step_valid` then stays 1 with the new data.
- `err_count` saturates at 2^CNT_W−1.
- `step` is stable while `step_valid` && !`step_ready`.
- `frame_err` and `err_count` fire only on a short or long frame. They are never triggered by stalls.

## Timing
- Reset values:
  - state FILL, `idx` 0.
  - `in_ready` 1, `step_valid` 0, `step` 0.
  - `frame_err` 0, `err_count` 0, `step_count` 0.
  - The fill buffer is also cleared to 0.
- Reset asserted mid-frame or while holding a step: all state clears immediately and the partial frame and held step are lost. The first word after deassertion is word 0.
- Latency: `step_valid` rises on the clock edge that accepts word 17. `step` is visible the cycle after the last word is presented.
- Throughput: one word per cycle sustained, i.e. one step per 18 cycles with no stall when the consumer takes each step within 17 cycles.
- `frame_err` asserts on the edge that accepts the offending word and drops on the next edge.
- `in_ready` is combinational from `step_ready`. There is no combinational path from `in_valid`/`in_data` to outputs.

## Test plan
- Good frame: send 18 words with word k = 0x1000_0000+k, `in_last` on word 17, `step_ready` = 1.
  - `step_valid` for exactly one cycle.
  - `step[31:0]` = 0x1000_0000 and `step[559:544]` = 0x0011.
  - `step_count` = 1, `err_count` = 0.
- Back-pressure: hold `step_ready` = 0 and send two good frames back-to-back.
  - The first 17 words of frame 2 are accepted; `in_ready` = 0 at word 17 of frame 2.
  - First step is held unchanged.
  - Raise `step_ready` for one cycle: frame 2 word 17 is accepted on that edge and `step` switches to frame 2 with `step_valid` staying 1.
- Short frame: assert `in_last` on word 5.
  - One `frame_err` pulse, `err_count` = 1, no `step_valid`.
  - The following good frame assembles correctly.
- Long frame: 18 words without `in_last`, then 3 extra words with `in_last` on the third.
  - `frame_err` on word 17 only, `err_count` = 1.
  - Next good frame assembles with `step_count` = 1.
- Reset mid-operation: assert `rst` asynchronously after word 9 of a frame while a step is held.
  - All outputs reach reset values without waiting for a clock edge.
  - A subsequent 18-word frame produces the correct step.
- Saturation: with CNT_W = 2, inject 5 short frames.
  - `err_count` = 3 after the third frame and stays at 3.
  - Five `frame_err` pulses observed.
